// File: rtl/arp_frame_sched_if.sv
// arp_frame_sched_if: decoded RX frame, resolve request/response, cache write and TX frame bundle.
interface arp_frame_sched_if;
  logic        s_frame_valid;
  logic        s_frame_ready;
  logic [15:0] s_arp_oper;
  logic [47:0] s_arp_sha;
  logic [31:0] s_arp_spa;
  logic [31:0] s_arp_tpa;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_ip;
  logic        resp_valid;
  logic        resp_error;
  logic [47:0] resp_mac;
  logic        cache_wr_valid;
  logic [31:0] cache_wr_ip;
  logic [47:0] cache_wr_mac;
  logic        m_frame_valid;
  logic        m_frame_ready;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [15:0] m_arp_htype;
  logic [15:0] m_arp_ptype;
  logic [7:0]  m_arp_hlen;
  logic [7:0]  m_arp_plen;
  logic [15:0] m_arp_oper;
  logic [47:0] m_arp_sha;
  logic [31:0] m_arp_spa;
  logic [47:0] m_arp_tha;
  logic [31:0] m_arp_tpa;
  logic        busy;
  modport slave (
    input  s_frame_valid, s_arp_oper, s_arp_sha, s_arp_spa, s_arp_tpa, req_valid, req_ip, m_frame_ready,
    output s_frame_ready, req_ready, resp_valid, resp_error, resp_mac, cache_wr_valid, cache_wr_ip,
           cache_wr_mac, m_frame_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_arp_htype,
           m_arp_ptype, m_arp_hlen, m_arp_plen, m_arp_oper, m_arp_sha, m_arp_spa, m_arp_tha,
           m_arp_tpa, busy
  );
  modport master (
    output s_frame_valid, s_arp_oper, s_arp_sha, s_arp_spa, s_arp_tpa, req_valid, req_ip, m_frame_ready,
    input  s_frame_ready, req_ready, resp_valid, resp_error, resp_mac, cache_wr_valid, cache_wr_ip,
           cache_wr_mac, m_frame_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_arp_htype,
           m_arp_ptype, m_arp_hlen, m_arp_plen, m_arp_oper, m_arp_sha, m_arp_spa, m_arp_tha,
           m_arp_tpa, busy
  );
endinterface

// File: rtl/arp_frame_sched.sv
// arp_frame_sched: ARP responder, single-outstanding resolver with timed retries, and TX frame arbiter.
module arp_frame_sched #(
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 125000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [47:0]      local_mac,
  input  logic [31:0]      local_ip,
  arp_frame_sched_if.slave bus
);
  localparam int TW = $clog2(RETRY_INTERVAL + 1);
  localparam int RW = $clog2(RETRY_COUNT + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t        state;
  logic [TW-1:0] timer;
  logic [RW-1:0] retries;
  logic [31:0]   req_ip_q;
  logic          reply_pending;
  logic [47:0]   rp_sha;
  logic [31:0]   rp_spa;
  logic          rx_acc, match, timeout, give_up, load, send_req, oper_arp;
  assign bus.s_frame_ready = !reply_pending;
  assign bus.req_ready     = state == IDLE;
  assign bus.busy          = state != IDLE;
  assign rx_acc   = bus.s_frame_valid && !reply_pending;
  assign oper_arp = bus.s_arp_oper == 16'd1 || bus.s_arp_oper == 16'd2;
  assign match    = rx_acc && bus.s_arp_oper == 16'd2 && bus.s_arp_spa == req_ip_q && state != IDLE;
  assign timeout  = state == WAIT && timer == TW'(RETRY_INTERVAL - 1);
  assign give_up  = timeout && retries == RW'(RETRY_COUNT - 1) && !match;
  assign load     = !bus.m_frame_valid || bus.m_frame_ready;
  // A match while still in SEND cancels the request that has not gone out yet.
  assign send_req = load && !reply_pending && state == SEND && !match;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      timer              <= '0;
      retries            <= '0;
      req_ip_q           <= '0;
      reply_pending      <= 1'b0;
      rp_sha             <= '0;
      rp_spa             <= '0;
      bus.resp_valid     <= 1'b0;
      bus.resp_error     <= 1'b0;
      bus.resp_mac       <= '0;
      bus.cache_wr_valid <= 1'b0;
      bus.cache_wr_ip    <= '0;
      bus.cache_wr_mac   <= '0;
      bus.m_frame_valid  <= 1'b0;
      bus.m_eth_dest_mac <= '0;
      bus.m_eth_src_mac  <= '0;
      bus.m_eth_type     <= '0;
      bus.m_arp_htype    <= '0;
      bus.m_arp_ptype    <= '0;
      bus.m_arp_hlen     <= '0;
      bus.m_arp_plen     <= '0;
      bus.m_arp_oper     <= '0;
      bus.m_arp_sha      <= '0;
      bus.m_arp_spa      <= '0;
      bus.m_arp_tha      <= '0;
      bus.m_arp_tpa      <= '0;
    end else begin
      bus.cache_wr_valid <= rx_acc && bus.s_arp_spa != '0 && oper_arp;
      if (rx_acc) begin
        bus.cache_wr_ip  <= bus.s_arp_spa;
        bus.cache_wr_mac <= bus.s_arp_sha;
      end
      bus.resp_valid <= match || give_up;
      if (match || give_up) begin
        bus.resp_error <= !match;
        bus.resp_mac   <= match ? bus.s_arp_sha : '0;
      end
      if (rx_acc && bus.s_arp_oper == 16'd1 && bus.s_arp_tpa == local_ip) begin
        reply_pending <= 1'b1;
        rp_sha        <= bus.s_arp_sha;
        rp_spa        <= bus.s_arp_spa;
      end else if (load && reply_pending) begin
        reply_pending <= 1'b0;
      end
      if (load) begin
        bus.m_frame_valid <= reply_pending || send_req;
        if (reply_pending || send_req) begin
          bus.m_eth_dest_mac <= reply_pending ? rp_sha : '1;
          bus.m_eth_src_mac  <= local_mac;
          bus.m_eth_type     <= 16'h0806;
          bus.m_arp_htype    <= 16'd1;
          bus.m_arp_ptype    <= 16'h0800;
          bus.m_arp_hlen     <= 8'd6;
          bus.m_arp_plen     <= 8'd4;
          bus.m_arp_oper     <= reply_pending ? 16'd2 : 16'd1;
          bus.m_arp_sha      <= local_mac;
          bus.m_arp_spa      <= local_ip;
          bus.m_arp_tha      <= reply_pending ? rp_sha : '0;
          bus.m_arp_tpa      <= reply_pending ? rp_spa : req_ip_q;
        end
      end
      if (bus.req_valid && state == IDLE) begin
        state    <= SEND;
        req_ip_q <= bus.req_ip;
        retries  <= '0;
      end else if (match) begin
        state <= IDLE;
      end else if (send_req) begin
        state <= WAIT;
        timer <= '0;
      end else if (timeout) begin
        state   <= give_up ? IDLE : SEND;
        retries <= give_up ? retries : retries + RW'(1);
      end else if (state == WAIT) begin
        timer <= timer + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_arp_frame_sched.sv
// tb_arp_frame_sched: directed test-plan scenarios plus random traffic checked against a behavioural model.
module tb_arp_frame_sched;
  localparam int RC = 3;
  localparam int RI = 16;
  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] LIP  = 32'h0a00_0005;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [47:0] local_mac = LMAC;
  logic [31:0] local_ip = LIP;
  int          n_chk = 0;
  int          n_fail = 0;
  arp_frame_sched_if bus();
  arp_frame_sched #(.RETRY_COUNT(RC), .RETRY_INTERVAL(RI)) dut (
    .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .local_ip(local_ip), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic        pend, resolving, need_send;
  logic [47:0] p_sha;
  logic [31:0] p_spa, target;
  int          sends;
  longint      cyc, deadline;
  logic        e_mv, e_rv, e_rerr, e_cv;
  logic [47:0] e_dst, e_tha, e_rmac, e_cmac;
  logic [15:0] e_oper;
  logic [31:0] e_tpa, e_cip;
  task automatic model_reset();
    pend = 0; resolving = 0; need_send = 0; p_sha = 0; p_spa = 0; target = 0;
    sends = 0; cyc = 0; deadline = 0;
    e_mv = 0; e_rv = 0; e_rerr = 0; e_cv = 0;
    e_dst = 0; e_tha = 0; e_rmac = 0; e_cmac = 0; e_oper = 0; e_tpa = 0; e_cip = 0;
  endtask
  // One clock of the reference: inputs of this cycle, predicting outputs after the next edge.
  task automatic model_step();
    logic acc, hit, tmo, last, ld;
    acc  = bus.s_frame_valid && !pend;
    hit  = acc && bus.s_arp_oper == 16'd2 && resolving && bus.s_arp_spa == target;
    tmo  = resolving && !need_send && cyc == deadline;
    last = tmo && sends == RC && !hit;
    ld   = !e_mv || bus.m_frame_ready;
    e_cv   = acc && bus.s_arp_spa != 0 && (bus.s_arp_oper == 16'd1 || bus.s_arp_oper == 16'd2);
    e_cip  = bus.s_arp_spa;
    e_cmac = bus.s_arp_sha;
    e_rv   = hit || last;
    e_rerr = last;
    e_rmac = hit ? bus.s_arp_sha : 48'h0;
    if (ld) begin
      if (pend) begin
        e_mv = 1; e_dst = p_sha; e_oper = 16'd2; e_tha = p_sha; e_tpa = p_spa; pend = 0;
      end else if (resolving && need_send && !hit) begin
        e_mv = 1; e_dst = '1; e_oper = 16'd1; e_tha = 0; e_tpa = target;
        need_send = 0; deadline = cyc + RI; sends++;
      end else begin
        e_mv = 0;
      end
    end
    if (acc && bus.s_arp_oper == 16'd1 && bus.s_arp_tpa == local_ip) begin
      pend = 1; p_sha = bus.s_arp_sha; p_spa = bus.s_arp_spa;
    end
    if (!resolving) begin
      if (bus.req_valid) begin
        resolving = 1; target = bus.req_ip; need_send = 1; sends = 0;
      end
    end else if (hit) begin
      resolving = 0;
    end else if (tmo) begin
      if (sends == RC) resolving = 0;
      else need_send = 1;
    end
    cyc++;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_m_valid", bus.m_frame_valid, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_error", bus.resp_error, 0);
      check("rst_cache_valid", bus.cache_wr_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_s_ready", bus.s_frame_ready, 1);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_dest", bus.m_eth_dest_mac, 0);
      check("rst_oper", bus.m_arp_oper, 0);
      check("rst_tpa", bus.m_arp_tpa, 0);
      check("rst_resp_mac", bus.resp_mac, 0);
      check("rst_cache_ip", bus.cache_wr_ip, 0);
      model_reset();
    end else begin
      check("s_ready", bus.s_frame_ready, !pend);
      check("req_ready", bus.req_ready, !resolving);
      check("busy", bus.busy, resolving);
      check("resp_valid", bus.resp_valid, e_rv);
      if (e_rv) begin
        check("resp_error", bus.resp_error, e_rerr);
        check("resp_mac", bus.resp_mac, e_rmac);
      end
      check("cache_valid", bus.cache_wr_valid, e_cv);
      if (e_cv) begin
        check("cache_ip", bus.cache_wr_ip, e_cip);
        check("cache_mac", bus.cache_wr_mac, e_cmac);
      end
      check("m_valid", bus.m_frame_valid, e_mv);
      if (e_mv) begin
        check("m_dest", bus.m_eth_dest_mac, e_dst);
        check("m_src", bus.m_eth_src_mac, local_mac);
        check("m_type", bus.m_eth_type, 16'h0806);
        check("m_htype", bus.m_arp_htype, 1);
        check("m_ptype", bus.m_arp_ptype, 16'h0800);
        check("m_hlen", bus.m_arp_hlen, 6);
        check("m_plen", bus.m_arp_plen, 4);
        check("m_oper", bus.m_arp_oper, e_oper);
        check("m_sha", bus.m_arp_sha, local_mac);
        check("m_spa", bus.m_arp_spa, local_ip);
        check("m_tha", bus.m_arp_tha, e_tha);
        check("m_tpa", bus.m_arp_tpa, e_tpa);
      end
      model_step();
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.s_frame_valid = 0;
    bus.req_valid = 0;
  endtask
  task automatic rx(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    bus.s_frame_valid = 1;
    bus.s_arp_oper = op;
    bus.s_arp_sha = sha;
    bus.s_arp_spa = spa;
    bus.s_arp_tpa = tpa;
  endtask
  task automatic req(input logic [31:0] ip);
    bus.req_valid = 1;
    bus.req_ip = ip;
  endtask
  logic [31:0] ips [4] = '{32'h0, 32'h0a00_0009, 32'h0a00_0033, 32'h0a00_0044};
  initial begin
    int stamps[$];
    int extra;
    bit done;
    clr();
    bus.m_frame_ready = 1;
    bus.req_ip = 0;
    rx(0, 0, 0, 0);
    bus.s_frame_valid = 0;
    #1 rst_n = 0;
    repeat (3) step();
    rst_n = 1;
    step();
    rx(1, 48'h02_00_00_00_00_11, 32'h0a00_0009, LIP);
    step();
    clr();
    @(negedge clk);
    check("plan_cache_valid", bus.cache_wr_valid, 1);
    check("plan_cache_ip", bus.cache_wr_ip, 32'h0a00_0009);
    check("plan_cache_mac", bus.cache_wr_mac, 48'h02_00_00_00_00_11);
    @(negedge clk);
    check("plan_reply_valid", bus.m_frame_valid, 1);
    check("plan_reply_oper", bus.m_arp_oper, 2);
    check("plan_reply_dest", bus.m_eth_dest_mac, 48'h02_00_00_00_00_11);
    check("plan_reply_tpa", bus.m_arp_tpa, 32'h0a00_0009);
    step();
    req(32'h0a00_0009);
    step();
    clr();
    repeat (4) step();
    rx(2, 48'h02_00_00_00_00_22, 32'h0a00_0009, LIP);
    step();
    clr();
    @(negedge clk);
    check("plan_resolve_valid", bus.resp_valid, 1);
    check("plan_resolve_error", bus.resp_error, 0);
    check("plan_resolve_mac", bus.resp_mac, 48'h02_00_00_00_00_22);
    check("plan_resolve_busy", bus.busy, 0);
    step();
    req(32'h0a00_0077);
    step();
    clr();
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.m_frame_valid && bus.m_arp_oper == 16'd1) stamps.push_back(i);
      if (bus.resp_valid) begin
        done = 1;
        check("plan_timeout_error", bus.resp_error, 1);
        check("plan_timeout_mac", bus.resp_mac, 0);
      end
    end
    check("plan_timeout_seen", done, 1);
    check("plan_request_count", stamps.size(), RC);
    if (stamps.size() == RC) begin
      check("plan_retry_gap1", stamps[1] - stamps[0], RI + 1);
      check("plan_retry_gap2", stamps[2] - stamps[1], RI + 1);
    end
    step();
    bus.m_frame_ready = 0;
    req(32'h0a00_0033);
    rx(1, 48'h02_00_00_00_00_44, 32'h0a00_0044, LIP);
    step();
    clr();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("plan_stall_valid", bus.m_frame_valid, 1);
      check("plan_stall_oper", bus.m_arp_oper, 2);
      check("plan_stall_dest", bus.m_eth_dest_mac, 48'h02_00_00_00_00_44);
      step();
    end
    bus.m_frame_ready = 1;
    @(negedge clk);
    check("plan_release_reply", bus.m_arp_oper, 2);
    step();
    @(negedge clk);
    check("plan_b2b_valid", bus.m_frame_valid, 1);
    check("plan_b2b_oper", bus.m_arp_oper, 1);
    check("plan_b2b_dest", bus.m_eth_dest_mac, 48'hff_ff_ff_ff_ff_ff);
    repeat (80) step();
    req(32'h0a00_0055);
    step();
    clr();
    repeat (RI) step();
    rx(2, 48'h02_00_00_00_00_66, 32'h0a00_0055, LIP);
    step();
    clr();
    @(negedge clk);
    check("plan_race_valid", bus.resp_valid, 1);
    check("plan_race_error", bus.resp_error, 0);
    check("plan_race_mac", bus.resp_mac, 48'h02_00_00_00_00_66);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.m_frame_valid) extra++;
    end
    check("plan_race_no_retry", extra, 0);
    step();
    req(32'h0a00_0077);
    step();
    clr();
    repeat (5) step();
    check("plan_busy_before_reset", bus.busy, 1);
    rst_n = 0;
    repeat (3) step();
    rst_n = 1;
    step();
    req(32'h0a00_0009);
    step();
    clr();
    @(negedge clk);
    check("plan_req_after_reset", bus.busy, 1);
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.m_frame_ready = $urandom_range(3) != 0;
      bus.s_frame_valid = $urandom_range(3) == 0;
      bus.s_arp_oper = 16'($urandom_range(3));
      bus.s_arp_sha = {16'h0200, 32'($urandom)};
      bus.s_arp_spa = ($urandom_range(4) == 0) ? 32'($urandom) : ips[$urandom_range(3)];
      bus.s_arp_tpa = $urandom_range(1) ? LIP : 32'h0a00_0099;
      bus.req_valid = $urandom_range(7) == 0;
      bus.req_ip = ips[1 + $urandom_range(1)];
    end
    step();
    clr();
    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
